// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle control unit and the multiply/divide
// sequencer: sequencer state encoding, MULT/DIV funct codes, default width.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MUL_RUN = 3'd1,
        MD_DIV_RUN = 3'd2,
        MD_DIV_FIX = 3'd3,
        MD_FINISH  = 3'd4
    } md_state_e;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer_if
// Request/response bundle between the control unit (master) and the
// multiply/divide sequencer (slave).
//   master -> slave : mult_start, div_start, abort, op_a, op_b
//   slave -> master : busy, done, hilo_we, div_zero, hi_out, lo_out
// -----------------------------------------------------------------------------
interface mult_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output mult_start, div_start, abort, op_a, op_b,
        input  busy, done, hilo_we, div_zero, hi_out, lo_out
    );

    modport slave (
        input  mult_start, div_start, abort, op_a, op_b,
        output busy, done, hilo_we, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/md_booth_step.sv
// -----------------------------------------------------------------------------
// md_booth_step
// One combinational radix-2 Booth iteration.
//   acc_i   : {upper[WIDTH-1:0], multiplier/lower[WIDTH-1:0], booth_bit}
//   mcand_i : signed multiplicand
//   acc_o   : accumulator after add/sub and 1-bit arithmetic right shift
// -----------------------------------------------------------------------------
module md_booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [2*WIDTH:0] acc_o
);

    logic [WIDTH:0] upper_x;
    logic [WIDTH:0] mcand_x;
    logic [WIDTH:0] sum;

    // The add/sub is done one bit wider than the upper half so that
    // -2^(W-1) multiplicands cannot overflow; the extra bit becomes the
    // sign shifted back in.
    always_comb begin
        upper_x = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
        mcand_x = {mcand_i[WIDTH-1], mcand_i};
        case (acc_i[1:0])
            2'b01:   sum = upper_x + mcand_x;
            2'b10:   sum = upper_x - mcand_x;
            default: sum = upper_x;
        endcase
        acc_o = {sum, acc_i[WIDTH:1]};
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes)
// engine producing the HI/LO pair for the multicycle control unit.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of mult_div_sequencer_if (starts, abort, operands in;
//           busy, done, hilo_we, div_zero, hi_out, lo_out back)
// Latency start-edge to done: MULT WIDTH+1, DIV WIDTH+2, divide-by-zero 1.
// -----------------------------------------------------------------------------
module mult_div_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_div_sequencer_if.slave  bus
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2*WIDTH:0] acc_step;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             cnt_last;

    md_booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_step)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ---------------- next state / datapath ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        a_mag    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
        b_mag    = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
        cnt_last = (cnt_q == CNT_W'(WIDTH-1));

        // Restoring step: shift in next dividend bit, subtract if it fits.
        // rem < divisor <= 2^(W-1), so the shifted value fits in W+1 bits.
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        div_ge    = (div_shift >= {1'b0, dvs_q});

        case (state_q)
            MD_IDLE: begin
                if (bus.mult_start) begin
                    state_d = MD_MUL_RUN;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, bus.op_b, 1'b0};
                    mcand_d = bus.op_a;
                    dz_d    = 1'b0;
                end else if (bus.div_start) begin
                    if (bus.op_b == '0) begin
                        state_d = MD_FINISH;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = MD_DIV_RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        negq_d  = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        negr_d  = bus.op_a[WIDTH-1];
                        dz_d    = 1'b0;
                    end
                end
            end
            MD_MUL_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    state_d = MD_FINISH;
                    hi_d    = acc_step[2*WIDTH:WIDTH+1];
                    lo_d    = acc_step[WIDTH:1];
                end
            end
            MD_DIV_RUN: begin
                rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) state_d = MD_DIV_FIX;
            end
            MD_DIV_FIX: begin
                // Negating 2^(W-1) wraps to itself, giving MIN/-1 = MIN.
                lo_d    = negq_q ? -quo_q : quo_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                state_d = MD_FINISH;
            end
            MD_FINISH: state_d = MD_IDLE;
            default:   state_d = MD_IDLE;
        endcase

        // Abort overrides everything, including a start or a pending write.
        if (bus.abort) begin
            state_d = MD_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.busy     = (state_q == MD_MUL_RUN) || (state_q == MD_DIV_RUN) ||
                       (state_q == MD_DIV_FIX);
        bus.done     = (state_q == MD_FINISH) && !bus.abort;
        bus.hilo_we  = bus.done && !dz_q;
        bus.div_zero = bus.done && dz_q;
        bus.hi_out   = hi_q;
        bus.lo_out   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mult_div_sequencer_if #(.WIDTH(32)) bus ();

    mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 = mult, 1 = div, 2 = both starts. inj: cycle to pulse a stray
    // div_start (0 = never). Cycle numbering: start edge is cycle 0.
    task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat, output int bcnt,
                          output logic we, output logic dz, output logic bdone);
        lat = -1; bcnt = 0; we = 1'b0; dz = 1'b0; bdone = 1'b1;
        @(negedge clk);
        bus.op_a = a;
        bus.op_b = b;
        bus.mult_start = (mode != 1);
        bus.div_start  = (mode != 0);
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (bus.done) begin
                lat = cyc; we = bus.hilo_we; dz = bus.div_zero; bdone = bus.busy;
                break;
            end
            if (bus.busy) bcnt++;
            if (cyc == inj) begin
                bus.div_start = 1'b1; bus.op_a = 32'h0000_1234; bus.op_b = 32'h0;
            end else begin
                bus.div_start = 1'b0;
            end
            @(negedge clk);
        end
        bus.div_start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.mult_start = 0; bus.div_start = 0; bus.abort = 0;
        bus.op_a = 0; bus.op_b = 0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.busy, bus.done, bus.hilo_we, bus.div_zero} !== 4'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000",
                               {bus.busy, bus.done, bus.hilo_we, bus.div_zero}); end
        checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi_out, bus.lo_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int lat, bc; logic we, dz, bd;
        run_op(0, 32'd7, 32'd6, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_lat: got %0d want 33", lat); end
        checks++; if (bc !== 32 || bd !== 1'b0) begin errors++;
            $display("FAIL mul_busy: got cnt=%0d at_done=%b want 32/0", bc, bd); end
        checks++; if (we !== 1'b1 || dz !== 1'b0) begin errors++;
            $display("FAIL mul_we: got we=%b dz=%b want 1/0", we, dz); end
        checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'd42) begin errors++;
            $display("FAIL mul_7x6: got %h/%h want 0/2a", bus.hi_out, bus.lo_out); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL mul_after: got done=%b busy=%b want 0/0", bus.done, bus.busy); end

        run_op(0, 32'hFFFF_FFFD, 32'd5, 0, lat, bc, we, dz, bd);
        checks++; if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFF1) begin errors++;
            $display("FAIL mul_neg: got %h/%h want ffffffff/fffffff1", bus.hi_out, bus.lo_out); end

        run_op(0, 32'h8000_0000, 32'h8000_0000, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 33 || bus.hi_out !== 32'h4000_0000 || bus.lo_out !== 32'h0) begin errors++;
            $display("FAIL mul_min: got lat=%0d %h/%h want 33 40000000/0", lat, bus.hi_out, bus.lo_out); end
    endtask

    task automatic test_div;
        int lat, bc; logic we, dz, bd;
        run_op(1, 32'hFFFF_FFF9, 32'd2, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 34 || bc !== 33 || we !== 1'b1) begin errors++;
            $display("FAIL div_timing: got lat=%0d busy=%0d we=%b want 34/33/1", lat, bc, we); end
        checks++; if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFFD) begin errors++;
            $display("FAIL div_m7_2: got %h/%h want ffffffff/fffffffd", bus.hi_out, bus.lo_out); end

        run_op(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, lat, bc, we, dz, bd);
        checks++; if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'd3) begin errors++;
            $display("FAIL div_m7_m2: got %h/%h want ffffffff/3", bus.hi_out, bus.lo_out); end

        run_op(1, 32'd7, 32'hFFFF_FFFE, 0, lat, bc, we, dz, bd);
        checks++; if (bus.hi_out !== 32'd1 || bus.lo_out !== 32'hFFFF_FFFD) begin errors++;
            $display("FAIL div_7_m2: got %h/%h want 1/fffffffd", bus.hi_out, bus.lo_out); end
    endtask

    task automatic test_div_zero;
        int lat, bc; logic we, dz, bd;
        run_op(1, 32'd5, 32'd0, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 1 || dz !== 1'b1 || we !== 1'b0) begin errors++;
            $display("FAIL dz_flags: got lat=%0d dz=%b we=%b want 1/1/0", lat, dz, we); end
        checks++; if (bus.hi_out !== 32'd1 || bus.lo_out !== 32'hFFFF_FFFD) begin errors++;
            $display("FAIL dz_hold: got %h/%h want 1/fffffffd", bus.hi_out, bus.lo_out); end

        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc, we, dz, bd);
        checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h8000_0000 || dz !== 1'b0) begin errors++;
            $display("FAIL div_min_m1: got %h/%h dz=%b want 0/80000000/0", bus.hi_out, bus.lo_out, dz); end
    endtask

    task automatic test_abort;
        logic saw;
        @(negedge clk);
        bus.op_a = 32'd9; bus.op_b = 32'd9; bus.mult_start = 1'b1;
        @(negedge clk);
        bus.mult_start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++;
            $display("FAIL abort_pre_busy: got %b want 1", bus.busy); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
            $display("FAIL abort_idle: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        saw = 1'b0;
        repeat (40) begin if (bus.done) saw = 1'b1; @(negedge clk); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done seen want none"); end
        checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h8000_0000) begin errors++;
            $display("FAIL abort_hold: got %h/%h want 0/80000000", bus.hi_out, bus.lo_out); end

        bus.mult_start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.mult_start = 1'b0; bus.abort = 1'b0;
        saw = bus.busy;
        repeat (40) begin if (bus.done) saw = 1'b1; @(negedge clk); end
        checks++; if (saw !== 1'b0) begin errors++;
            $display("FAIL abort_start: got activity want start dropped"); end
    endtask

    task automatic test_ignore_start;
        int lat, bc; logic we, dz, bd;
        run_op(0, 32'd123, 32'hFFFF_FFD3, 5, lat, bc, we, dz, bd);
        checks++; if (lat !== 33 || dz !== 1'b0 || we !== 1'b1) begin errors++;
            $display("FAIL ign_flags: got lat=%0d dz=%b we=%b want 33/0/1", lat, dz, we); end
        checks++; if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_EA61) begin errors++;
            $display("FAIL ign_result: got %h/%h want ffffffff/ffffea61", bus.hi_out, bus.lo_out); end
    endtask

    task automatic test_both_start;
        int lat, bc; logic we, dz, bd;
        run_op(2, 32'd100, 32'd7, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 33 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'd700) begin errors++;
            $display("FAIL both_start: got lat=%0d %h/%h want 33 0/2bc", lat, bus.hi_out, bus.lo_out); end
    endtask

    task automatic test_async_reset;
        int lat, bc; logic we, dz, bd; logic saw;
        @(negedge clk);
        bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.div_start = 1'b1;
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.hilo_we, bus.div_zero} !== 4'b0 ||
                      bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin errors++;
            $display("FAIL areset_out: got ctl=%b %h/%h want 0 0/0",
                     {bus.busy, bus.done, bus.hilo_we, bus.div_zero}, bus.hi_out, bus.lo_out); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin if (bus.done || bus.busy) saw = 1'b1; @(negedge clk); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL areset_no_done: got activity want none"); end
        run_op(0, 32'd3, 32'd4, 0, lat, bc, we, dz, bd);
        checks++; if (lat !== 33 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'd12) begin errors++;
            $display("FAIL areset_mult: got lat=%0d %h/%h want 33 0/c", lat, bus.hi_out, bus.lo_out); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_abort();
        test_ignore_start();
        test_both_start();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
